// File: rtl/kj_audio_clock_divider.sv
// Audio serial clock generator: derives bclk/lrclk and slot/bit indices from refclk after PLL lock.
// Latency: all outputs registered; first bclk_fall/frame_start one cycle after LOCK_WAIT locked SYNC cycles.
module kj_audio_clock_divider #(
    parameter int MCLK_DIV   = 4,
    parameter int SLOTS      = 2,
    parameter int SLOT_BITS  = 32,
    parameter int LOCK_WAIT  = 256,
    parameter int FSYNC_MODE = 0
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       enable,
    input  logic       err_clr,
    output logic       bclk,
    output logic       lrclk,
    output logic       bclk_fall,
    output logic       frame_start,
    output logic [2:0] slot_idx,
    output logic [4:0] bit_idx,
    output logic       running,
    output logic       err_unlock
);

    localparam int              DIV_W     = $clog2(MCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
    localparam logic [4:0]      BIT_TOP   = 5'(SLOT_BITS - 1);
    localparam logic [2:0]      SLOT_LAST = 3'(SLOTS - 1);
    localparam logic [2:0]      SLOT_LHI  = 3'(SLOTS / 2 - 1);
    localparam logic [15:0]     LOCK_LAST = 16'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [15:0]      lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       slot_q, slot_d;
    logic [4:0]       bit_q, bit_d;
    logic             err_q, err_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             fall_q, fall_d;
    logic             fs_q, fs_d;
    logic             running_q, running_d;
    logic             frame_wrap;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        div_cnt_d  = div_cnt_q;
        slot_d     = slot_q;
        bit_d      = bit_q;
        err_d      = err_q;
        frame_wrap = (div_cnt_q == DIV_LAST) && (bit_q == 5'd0) && (slot_q == SLOT_LAST);

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                lock_cnt_d = 16'd0;
                if (enable && pll_locked) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (!pll_locked || !enable) begin
                    state_d = IDLE;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d = RUN;
                end else begin
                    lock_cnt_d = lock_cnt_q + 16'd1;
                end
            end
            RUN, DRAIN: begin
                if (!pll_locked) begin
                    // Unlock outranks a same-cycle err_clr.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
                    if (div_cnt_q == DIV_LAST) begin
                        if (bit_q == 5'd0) begin
                            bit_d  = BIT_TOP;
                            slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end
                    if (enable) begin
                        state_d = RUN;
                    end else if (frame_wrap) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Counters sit at their frame-start values whenever the clocks are stopped.
        if (state_d == IDLE || state_d == SYNC) begin
            div_cnt_d = '0;
            slot_d    = 3'd0;
            bit_d     = BIT_TOP;
        end

        running_d = (state_d == RUN) || (state_d == DRAIN);
        bclk_d    = running_d && (div_cnt_d >= DIV_HALF);
        fall_d    = running_d && (div_cnt_d == '0);
        fs_d      = fall_d && (slot_d == 3'd0) && (bit_d == BIT_TOP);
        if (FSYNC_MODE == 1) begin
            lrclk_d = running_d && (slot_d == 3'd0) && (bit_d == BIT_TOP);
        end else begin
            // I2S: word clock leads the slot boundary by one bit.
            lrclk_d = running_d &&
                      (((slot_d == SLOT_LHI) && (bit_d == 5'd0)) ||
                       ((slot_d > SLOT_LHI) && !((slot_d == SLOT_LAST) && (bit_d == 5'd0))));
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_cnt_q <= 16'd0;
            div_cnt_q  <= '0;
            slot_q     <= 3'd0;
            bit_q      <= BIT_TOP;
            err_q      <= 1'b0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            fall_q     <= 1'b0;
            fs_q       <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            div_cnt_q  <= div_cnt_d;
            slot_q     <= slot_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            fall_q     <= fall_d;
            fs_q       <= fs_d;
            running_q  <= running_d;
        end
    end

    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign bclk_fall   = fall_q;
    assign frame_start = fs_q;
    assign slot_idx    = slot_q;
    assign bit_idx     = bit_q;
    assign running     = running_q;
    assign err_unlock  = err_q;

endmodule

// File: doc/kj_audio_clock_divider.md
KJ_AUDIO_CLOCK_DIVIDER -- requirements
Module: kj_audio_clock_divider

Interface
REQ-001 Parameter MCLK_DIV, default 4: refclk cycles per bclk period; even, 2..64.
REQ-002 Parameter SLOTS, default 2: TDM slots (channels) per frame; even, 2..8.
REQ-003 Parameter SLOT_BITS, default 32: bclk periods per slot; 8..32.
REQ-004 Parameter LOCK_WAIT, default 256: refclk cycles pll_locked must stay high before running; 1..65535.
REQ-005 Parameter FSYNC_MODE, default 0: 0 = I2S 50% lrclk, 1 = one-bclk-wide frame pulse.
REQ-006 refclk  in  1  audio master clock (12.288 MHz PLL output); all logic on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 pll_locked  in  1  PLL lock indicator, treated as synchronous to refclk.
REQ-009 enable  in  1  level request to run the serial clocks.
REQ-010 err_clr  in  1  one-cycle pulse clearing err_unlock.
REQ-011 bclk  out  1  registered bit clock.
REQ-012 lrclk  out  1  registered frame/word clock.
REQ-013 bclk_fall  out  1  one-cycle strobe: cycle in which bclk is first low in a period.
REQ-014 frame_start  out  1  one-cycle strobe coincident with bclk_fall of slot 0, bit SLOT_BITS-1.
REQ-015 slot_idx  out  3  current slot, 0..SLOTS-1.
REQ-016 bit_idx  out  5  current bit, SLOT_BITS-1 down to 0 (MSB first).
REQ-017 running  out  1  high in RUN and DRAIN.
REQ-018 err_unlock  out  1  sticky: pll_locked fell while running.

Function
REQ-019 The block SHALL implement states IDLE, SYNC, RUN, DRAIN.
REQ-020 IDLE -> SYNC when enable=1 and pll_locked=1; lock counter cleared on entry.
REQ-021 SYNC SHALL count consecutive locked cycles; at count LOCK_WAIT-1 -> RUN; enable=0 -> IDLE.
REQ-022 On RUN entry div_cnt=0, slot_idx=0, bit_idx=SLOT_BITS-1, and bclk_fall and frame_start SHALL assert in the first RUN cycle.
REQ-023 div_cnt SHALL wrap MCLK_DIV-1 -> 0; bclk=0 for div_cnt < MCLK_DIV/2, else 1 (50% duty).
REQ-024 bclk_fall SHALL assert exactly once per bclk period, at div_cnt=0.
REQ-025 bit_idx/slot_idx SHALL advance in the bclk_fall cycle; bit_idx 0 -> SLOT_BITS-1 with slot_idx+1; slot SLOTS-1, bit 0 -> slot 0 (frame wrap).
REQ-026 FSYNC_MODE=0: lrclk SHALL change one bclk early (I2S delay): low from the last bit of slot SLOTS-1 through bit 1 of slot SLOTS/2-1, high from bit 0 of slot SLOTS/2-1 through bit 1 of slot SLOTS-1.
REQ-027 FSYNC_MODE=1: lrclk SHALL be high for exactly the bclk period of slot 0, bit SLOT_BITS-1, low otherwise.
REQ-028 enable=0 in RUN -> DRAIN; current frame completes; at the frame wrap the block SHALL enter IDLE instead of issuing frame_start.
REQ-029 enable=1 again during DRAIN SHALL return to RUN with no frame gap.
REQ-030 pll_locked=0 in SYNC -> IDLE; in RUN or DRAIN -> IDLE next cycle and err_unlock set.
REQ-031 err_clr and a simultaneous unlock event: set wins.
REQ-032 In IDLE and SYNC bclk, lrclk, strobes, running=0, slot_idx=0, bit_idx=SLOT_BITS-1.
REQ-033 Frame length SHALL equal MCLK_DIV*SLOTS*SLOT_BITS refclk cycles exactly.

Reset
REQ-034 rst_n=0 SHALL force IDLE, counters 0, bclk=lrclk=bclk_fall=frame_start=running=err_unlock=0, slot_idx=0, bit_idx=SLOT_BITS-1, asynchronously.
REQ-035 Reset release SHALL take effect at the next refclk edge; reset mid-frame SHALL abandon the frame without glitch pulses on bclk.

Verification
REQ-036 Defaults, pll_locked=1, enable=1 from reset release -> first bclk_fall/frame_start after 256 SYNC cycles; frame_start period 256 refclk; bclk period 4.
REQ-037 Defaults, FSYNC_MODE=0 -> lrclk falls 4 refclk before frame_start, rises 128 refclk later; high 128, low 128.
REQ-038 SLOTS=8, SLOT_BITS=16, FSYNC_MODE=1 -> lrclk high 4 refclk per frame, frame period 512, slot_idx steps 0..7.
REQ-039 enable=0 at bit 20 of slot 1 -> frame completes, running=0 at wrap, no further frame_start; reassert during drain -> seamless frame.
REQ-040 pll_locked=0 mid-frame -> next cycle IDLE, bclk=0, err_unlock=1; err_clr -> 0; relock needs full LOCK_WAIT.
REQ-041 rst_n pulse mid-frame -> all outputs 0 immediately, restart via SYNC.
